// File: rtl/mc_run_ctrl.sv
// rtl/mc_run_ctrl.sv - run controller: core reset hold, halt capture, completion/watchdog status
//
// Optional feature macro: MC_RUN_CTRL_AUTOSTART_EN
//   defined   : the first cycle after rst deasserts acts as a start request
//   undefined : the block waits in IDLE for start
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset of this block
//   start       start / re-run request, level sampled each cycle
//   halted      per-core halted flags from the cores
//   core_rst_n  active-low reset driven to the cores
//   running     high while in RUN
//   done        high while in DONE (every core has halted)
//   timed_out   high while in TIMEOUT
//   halt_seen   sticky per-core "has halted" flags
//   run_cycles  cycles spent in RUN for the current run (saturating)
//   halt_sel    core index for halt_cycle readback
//   halt_cycle  run_cycles value captured at the first halt of core halt_sel
module mc_run_ctrl #(
    parameter int NCORES         = 4,
    parameter int RESET_CYCLES   = 10,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 32,
    localparam int SEL_W         = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NCORES-1:0] halted,
    output logic              core_rst_n,
    output logic              running,
    output logic              done,
    output logic              timed_out,
    output logic [NCORES-1:0] halt_seen,
    output logic [CNT_W-1:0]  run_cycles,
    input  logic [SEL_W-1:0]  halt_sel,
    output logic [CNT_W-1:0]  halt_cycle
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET_HOLD,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              launch;
    logic              start_eff;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0]  cap [NCORES];

`ifdef MC_RUN_CTRL_AUTOSTART_EN
    // High only in the first cycle after rst drops, standing in for start.
    logic auto_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            auto_pend <= 1'b1;
        end else begin
            auto_pend <= 1'b0;
        end
    end

    assign start_eff = start | auto_pend;
`else
    assign start_eff = start;
`endif

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start_eff) begin
                    state_next = S_RESET_HOLD;
                    launch     = 1'b1;
                end
            end
            S_RESET_HOLD: begin
                if (hold_cnt == '0) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                // Current-cycle halts count, so completion wins over a
                // timeout detected in the same cycle.
                if (&(halt_seen | halted)) begin
                    state_next = S_DONE;
                end else if (run_cycles == RUN_LAST) begin
                    state_next = S_TIMEOUT;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they never
    // glitch on state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            core_rst_n <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
            timed_out  <= 1'b0;
        end else begin
            state      <= state_next;
            core_rst_n <= (state_next == S_RUN) || (state_next == S_DONE) ||
                          (state_next == S_TIMEOUT);
            running    <= (state_next == S_RUN);
            done       <= (state_next == S_DONE);
            timed_out  <= (state_next == S_TIMEOUT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt   <= '0;
            halt_seen  <= '0;
            run_cycles <= '0;
            for (int i = 0; i < NCORES; i++) begin
                cap[i] <= '0;
            end
        end else if (launch) begin
            hold_cnt   <= HOLD_LOAD;
            halt_seen  <= '0;
            run_cycles <= '0;
            for (int i = 0; i < NCORES; i++) begin
                cap[i] <= '0;
            end
        end else begin
            case (state)
                S_RESET_HOLD: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (run_cycles != '1) begin
                        run_cycles <= run_cycles + 1'b1;
                    end
                    // First-halt capture uses the pre-increment count.
                    for (int i = 0; i < NCORES; i++) begin
                        if (halted[i] && !halt_seen[i]) begin
                            halt_seen[i] <= 1'b1;
                            cap[i]       <= run_cycles;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        halt_cycle = '0;
        if ({{(32 - SEL_W){1'b0}}, halt_sel} < 32'(NCORES)) begin
            halt_cycle = cap[halt_sel];
        end
    end

endmodule

// File: tb/tb_mc_run_ctrl.sv
// tb/tb_mc_run_ctrl.sv - self-checking bench for mc_run_ctrl with a run-level reference model
module tb_mc_run_ctrl;

    localparam int NC  = 4;
    localparam int RC  = 10;
    localparam int TO  = 50;
    localparam int CW  = 32;
    localparam int SW  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NC-1:0] halted = '0;
    logic [SW-1:0] halt_sel = '0;
    logic          core_rst_n;
    logic          running;
    logic          done;
    logic          timed_out;
    logic [NC-1:0] halt_seen;
    logic [CW-1:0] run_cycles;
    logic [CW-1:0] halt_cycle;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-core stimulus: first RUN cycle the core halts (-1 = never) and
    // what halted does afterwards (0 stays high, 1 single pulse, 2 random).
    int f  [NC];
    int md [NC];

    mc_run_ctrl #(
        .NCORES(NC), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .halted(halted),
        .core_rst_n(core_rst_n), .running(running), .done(done),
        .timed_out(timed_out), .halt_seen(halt_seen), .run_cycles(run_cycles),
        .halt_sel(halt_sel), .halt_cycle(halt_cycle)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic halt_val(input int i, input int k);
        if (f[i] < 0 || k < f[i]) return 1'b0;
        if (k == f[i]) return 1'b1;
        if (md[i] == 0) return 1'b1;
        if (md[i] == 1) return 1'b0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_reset_values(input string name);
        n_cmp++;
        if ({core_rst_n, running, done, timed_out} !== 4'b0000) begin
            n_bad++;
            $display("FAIL %s flags: got %b want 0000", name, {core_rst_n, running, done, timed_out});
        end
        n_cmp++;
        if (halt_seen !== '0 || run_cycles !== '0) begin
            n_bad++;
            $display("FAIL %s counters: seen %b run_cycles %0d want 0/0", name, halt_seen, run_cycles);
        end
        for (int i = 0; i < NC; i++) begin
            halt_sel = SW'(i);
            #1;
            n_cmp++;
            if (halt_cycle !== '0) begin
                n_bad++;
                $display("FAIL %s halt_cycle[%0d]: got %0d want 0", name, i, halt_cycle);
            end
        end
    endtask

    // Behaviour right after rst drops: wait in IDLE, or with autostart run
    // through the hold into RUN and finish at once with all cores halted.
    task automatic check_after_reset(input string name);
`ifdef MC_RUN_CTRL_AUTOSTART_EN
        halted = '1;
        for (int j = 0; j < RC + 2; j++) step();
        n_cmp++;
        if (done !== 1'b1 || run_cycles !== 1) begin
            n_bad++;
            $display("FAIL %s autostart: done %b run_cycles %0d want 1/1", name, done, run_cycles);
        end
        halted = '0;
`else
        for (int j = 0; j < 5; j++) begin
            start = 1'b0;
            halted = NC'($urandom);
            step();
            n_cmp++;
            if (core_rst_n !== 1'b0 || running !== 1'b0) begin
                n_bad++;
                $display("FAIL %s idle: core_rst_n %b running %b want 0/0", name, core_rst_n, running);
            end
        end
        halted = '0;
`endif
    endtask

    // One complete run from a start pulse. abort_at >= 0 asserts rst in
    // that RUN cycle and returns right after the reset edge.
    task automatic do_run(input string name, input int abort_at);
        logic [NC-1:0] exp_seen;
        int exp_first [NC];
        bit exp_done;
        int exp_len;
        int last;
        int k;
        bit ended;
        exp_seen = '0;
        exp_done = 1'b1;
        last = 0;
        for (int i = 0; i < NC; i++) begin
            if (f[i] >= 0 && f[i] < TO) begin
                exp_first[i] = f[i];
                exp_seen[i] = 1'b1;
                if (f[i] > last) last = f[i];
            end else begin
                exp_first[i] = 0;
                exp_done = 1'b0;
            end
        end
        exp_len = exp_done ? last + 1 : TO;

        start = 1'b1;
        halted = NC'($urandom);
        step();
        for (int j = 0; j < RC; j++) begin
            n_cmp++;
            if (core_rst_n !== 1'b0 || running !== 1'b0) begin
                n_bad++;
                $display("FAIL %s hold%0d: core_rst_n %b running %b want 0/0", name, j, core_rst_n, running);
            end
            start = 1'($urandom_range(0, 1));
            halted = NC'($urandom);
            step();
        end

        k = 0;
        ended = 1'b0;
        while (!ended && k < TO + 5) begin
            n_cmp++;
            if (running !== 1'b1 || core_rst_n !== 1'b1 || run_cycles !== k) begin
                n_bad++;
                $display("FAIL %s run%0d: running %b core_rst_n %b run_cycles %0d want 1/1/%0d",
                         name, k, running, core_rst_n, run_cycles, k);
            end
            if (k == abort_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                start = 1'b0;
                return;
            end
            for (int i = 0; i < NC; i++) halted[i] = halt_val(i, k);
            start = 1'($urandom_range(0, 1));
            step();
            k++;
            if (done || timed_out) ended = 1'b1;
        end
        start = 1'b0;

        n_cmp++;
        if (!ended || k != exp_len) begin
            n_bad++;
            $display("FAIL %s length: ended %b after %0d RUN cycles want %0d", name, ended, k, exp_len);
        end
        n_cmp++;
        if (done !== exp_done || timed_out !== !exp_done || running !== 1'b0 || core_rst_n !== 1'b1) begin
            n_bad++;
            $display("FAIL %s status: done %b timed_out %b running %b core_rst_n %b want %b/%b/0/1",
                     name, done, timed_out, running, core_rst_n, exp_done, !exp_done);
        end
        for (int r = 0; r < 3; r++) begin
            n_cmp++;
            if (run_cycles !== exp_len || halt_seen !== exp_seen) begin
                n_bad++;
                $display("FAIL %s frozen%0d: run_cycles %0d seen %b want %0d/%b",
                         name, r, run_cycles, halt_seen, exp_len, exp_seen);
            end
            for (int i = 0; i < NC; i++) begin
                halt_sel = SW'(i);
                #1;
                n_cmp++;
                if (halt_cycle !== exp_first[i]) begin
                    n_bad++;
                    $display("FAIL %s halt_cycle[%0d]: got %0d want %0d", name, i, halt_cycle, exp_first[i]);
                end
            end
            halted = NC'($urandom);
            step();
        end
    endtask

    task automatic set_case(input int f0, input int f1, input int f2, input int f3,
                            input int m0, input int m1, input int m2, input int m3);
        f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
        md[0] = m0; md[1] = m1; md[2] = m2; md[3] = m3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        halted = '1;
        step();
        step();
        check_reset_values("reset");
        rst = 1'b0;
        start = 1'b0;
        check_after_reset("post_reset");
    endtask

    task automatic test_directed();
        set_case(5, 9, 9, 20, 0, 0, 0, 0);
        do_run("staggered", -1);
        set_case(5, 9, 3, 20, 0, 2, 1, 0);
        do_run("pulse", -1);
        set_case(1, 2, 3, -1, 0, 0, 0, 0);
        do_run("timeout", -1);
        set_case(10, 20, 30, 49, 0, 0, 0, 1);
        do_run("done_at_limit", -1);
        set_case(0, 4, 50, 7, 0, 0, 0, 0);
        do_run("halt_past_limit", -1);
        set_case(0, 0, 0, 0, 1, 1, 1, 1);
        do_run("all_first_cycle", -1);
    endtask

    task automatic test_reset_mid_run();
        set_case(5, 10, -1, -1, 0, 0, 0, 0);
        do_run("mid_run", 30);
        check_reset_values("mid_run_reset");
        check_after_reset("mid_run_after");
        set_case(2, 3, 4, 6, 2, 2, 2, 2);
        do_run("rerun", -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < NC; i++) begin
                f[i] = ($urandom_range(0, 6) == 0) ? -1 : int'($urandom_range(0, 55));
                md[i] = int'($urandom_range(0, 2));
            end
            do_run($sformatf("rand%0d", n), -1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
